// File: rtl/mod_cnt_chain_pkg.sv
// Shared definitions for the cascaded modulo counter: default digit width,
// direction encoding and the load clamp helper.
package mod_cnt_pkg;

    localparam int unsigned DEF_DW = 4;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    function automatic int unsigned clamp(int unsigned value, int unsigned max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/mod_cnt_chain_if.sv
// Control/data bundle of the cascaded modulo counter; master drives the
// controls and load value, slave returns the count and chain carry.
interface mod_cnt_chain_if #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned DW     = 4
);
    logic                   clr;
    logic                   ld;
    logic                   en;
    logic                   up;
    logic [DIGITS*DW-1:0]   data;
    logic [DIGITS*DW-1:0]   q;
    logic                   co;

    modport master (output clr, ld, en, up, data, input q, co);
    modport slave  (input clr, ld, en, up, data, output q, co);
endinterface

// File: rtl/mod_cnt_chain_digit.sv
// One modulo digit of the chain: clear/load/step with wrap at MAXD.
// Down-counting is compiled only when MOD_CNT_DOWN_EN is defined.
module mod_cnt_digit
    import mod_cnt_pkg::*;
#(
    parameter int unsigned     DW   = DEF_DW,
    parameter logic [DW-1:0]   MAXD = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            ld_i,
    input  logic [DW-1:0]   ld_val_i,
    input  logic            step_i,
`ifdef MOD_CNT_DOWN_EN
    input  dir_e            dir_i,
`endif
    output logic            term_o,
    output logic [DW-1:0]   q_o
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] inc;

    assign inc = (q_q == MAXD) ? '0 : q_q + 1'b1;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = ld_val_i;
        end else if (step_i) begin
`ifdef MOD_CNT_DOWN_EN
            if (dir_i == DIR_DN) begin
                q_d = (q_q == '0) ? MAXD : q_q - 1'b1;
            end else begin
                q_d = inc;
            end
`else
            q_d = inc;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

`ifdef MOD_CNT_DOWN_EN
    assign term_o = (dir_i == DIR_UP) ? (q_q == MAXD) : (q_q == '0);
`else
    assign term_o = (q_q == MAXD);
`endif

    assign q_o = q_q;

endmodule

// File: rtl/mod_cnt_chain.sv
// Cascaded modulo counter of DIGITS stages with combinational chain carry.
// Define MOD_CNT_DOWN_EN to honour the up input (down-count and borrow).
module mod_cnt_chain
    import mod_cnt_pkg::*;
#(
    parameter int unsigned              DIGITS = 2,
    parameter int unsigned              DW     = DEF_DW,
    parameter logic [DIGITS*DW-1:0]     MAXV   = 8'h59
) (
    input  logic            clk,
    input  logic            rst,
    mod_cnt_chain_if.slave  bus
);

    localparam int unsigned W = DIGITS * DW;

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step;
    logic [W-1:0]      q_all;

`ifdef MOD_CNT_DOWN_EN
    dir_e dir;
    assign dir = dir_e'(bus.up);
`else
    logic unused_up;
    assign unused_up = bus.up;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [DW-1:0] MAXD = MAXV[g*DW +: DW];

        logic [DW-1:0] ld_val;
        assign ld_val = DW'(clamp(32'(bus.data[g*DW +: DW]), 32'(MAXD)));

        // Digit g advances only while every lower digit sits at its terminal value.
        if (g == 0) begin : g_lsd
            assign step[g] = bus.en;
        end else begin : g_upper
            assign step[g] = step[g-1] & term[g-1];
        end

        mod_cnt_digit #(
            .DW   (DW),
            .MAXD (MAXD)
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (bus.clr),
            .ld_i     (bus.ld),
            .ld_val_i (ld_val),
            .step_i   (step[g]),
`ifdef MOD_CNT_DOWN_EN
            .dir_i    (dir),
`endif
            .term_o   (term[g]),
            .q_o      (q_all[g*DW +: DW])
        );
    end

    assign bus.q  = q_all;
    assign bus.co = step[DIGITS-1] & term[DIGITS-1];

endmodule

// File: doc/mod_cnt_chain.md
# mod_cnt_chain

Parametrised cascaded modulo counter: a chain of `DIGITS` digit stages, each wrapping at its own maximum value, with synchronous clear, synchronous load, enable, up/down direction and a chain carry/borrow output. It generalises the single fixed mod-6 digit with asynchronous load/clear into one block. It sits between the timebase tick generator and the seven-segment display path of the clock designs, for example a seconds field 00–59 as two digits with maxima 9 and 5. Several chains cascade through `co` → `en`.

## Interface

Parameters:
- `DIGITS`, default 2: number of digit stages; minimum 1.
- `DW`, default 4: bits per digit.
- `MAXV`, default `8'h59`: packed per-digit maximum value, `DIGITS*DW` bits.
  - Digit i occupies `[i*DW +: DW]`; digit 0 is least significant.
  - Every field must be ≥ 1.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `clr`: input, 1 bit. Synchronous clear of all digits.
- `ld`: input, 1 bit. Synchronous load of `data`.
- `en`: input, 1 bit. Count enable; one step per enabled clock.
- `up`: input, 1 bit. Direction: 1 counts up, 0 counts down.
- `data`: input, `DIGITS*DW` bits. Packed load value.
- `q`: output, `DIGITS*DW` bits. Packed registered count.
- `co`: output, 1 bit. Combinational chain carry (counting up) or borrow (counting down).

## Operation

- Priority at each rising edge, highest first: `rst` > `clr` > `ld` > `en` > hold.
- Reset:
  - `rst` high forces `q` to all-zero immediately, without waiting for a clock edge.
  - `co` is then 0, unless `en` is high, `up` is 0 and the all-zero state counts as terminal for down-counting.
  - Release of `rst` is synchronised upstream; the first edge after release evaluates normally.
- Clear: `clr` high sets all digits to 0 and ignores `ld` and `en`.
- Load:
  - `ld` high writes each digit from its `data` field.
  - A field greater than its `MAXV` field is clamped to `MAXV`.
  - The counter does not count in a load cycle.
- Terminal state, per digit i:
  - `term[i]` = (digit == `MAXV[i]`) when `up` = 1.
  - `term[i]` = (digit == 0) when `up` = 0.
- Stage enable:
  - `step[0]` = `en`.
  - `step[i]` = `en` AND `term[0..i-1]` all true.
- Counting a digit with `step[i]` set:
  - Up: if at `MAXV[i]` it wraps to 0, otherwise it adds 1.
  - Down: if at 0 it wraps to `MAXV[i]`, otherwise it subtracts 1.
  - All digit arithmetic is modulo `DW` bits and never overflows, because every digit value stays ≤ `MAXV[i]`.
- Carry/borrow:
  - `co` = `en` AND `term` true on all digits; it is purely combinational.
  - In the same cycle as `co`, the whole chain wraps (59→00 counting up, 00→59 counting down).
- Direction change: `up` may toggle on any cycle; it takes effect at the same edge, with no pipeline to drain.

## Timing

- `q` latency: 1 clock from the sampled `clr`/`ld`/`en` to the new value on `q`.
- `co`: zero latency from `en`, `up` and `q`, and valid in the same cycle. Downstream chains consume it as their `en` on the same edge.
- Simultaneous `ld` and `en`: the load wins and no count is applied. `co` may still be asserted combinationally in that cycle, so downstream users qualify it with their own `ld`.
- `rst` asserted mid-count: `q` becomes 0 asynchronously and any step in progress is discarded.

## Configuration

- Macro `MOD_CNT_DOWN_EN`.
- Defined:
  - `up` is honoured and both directions are implemented as described.
- Undefined:
  - `up` is ignored and treated as constant 1.
  - Down-count and borrow logic is not compiled.
  - `co` is a carry only.
  - The port list is unchanged, so integration is identical.

## Structure

- Shared package `mod_cnt_pkg`:
  - Default `DW` constant.
  - Clamp function `clamp(value, max)` used on load.
  - Direction encoding constants `DIR_UP` and `DIR_DN`.
- Sub-module `mod_cnt_digit`:
  - Holds one digit register with clr, ld (pre-clamped), step and up inputs, and a `term` output.
  - `mod_cnt_chain` instantiates it `DIGITS` times in a generate loop and builds the `step` prefix-AND.

## Test plan

- Reset, then `en`=1, `up`=1 held for 60 cycles: `q` sequences 00, 01 … 09, 10 … 59, then 00. `co` is high only in the cycle where `q`=59.
- `ld`=1, `data`=`8'h7C`: `q` becomes 59 (7 clamps to 5, C clamps to 9). With `ld` and `en` both high, `q` equals the loaded value and does not increment.
- `q`=00, `en`=1, `up`=0:
  - Next `q`=59 and `co`=1 in the 00 cycle.
  - From 50 the next value is 49.
  - With `MOD_CNT_DOWN_EN` undefined, the same stimulus gives 00→01.
- `clr` and `ld` asserted together with `q`=37: next `q`=00.
- `rst` pulsed between edges while `q`=42: `q`=00 before the next edge. Counting resumes as 01 on the first enabled edge after release.
- `DIGITS`=3, `MAXV`=`12'h235`:
  - Counting up wraps 235→000, `co`=1 at 235.
  - Digit 1 steps only when digit 0 is 5 (for example 035→100).
